// File: rtl/cmp_pkg.sv
// Shared types and the golden comparison rule for the comparator sweep checker.
// Every other checker file imports this package.
package cmp_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        FINISH
    } state_e;

    typedef struct packed {
        logic equal;
        logic greater;
        logic lesser;
    } flags_t;

    // Operands are zero-extended to MAX_WIDTH by the caller, so the comparison is unsigned.
    function automatic flags_t expect_flags(input logic [MAX_WIDTH-1:0] a,
                                            input logic [MAX_WIDTH-1:0] b);
        flags_t f;
        f.equal   = (a == b);
        f.greater = (a > b);
        f.lesser  = (a < b);
        return f;
    endfunction

endpackage

// File: rtl/cmp_sweep_checker_if.sv
// Operand and flag bus between the sweep checker and the comparator under test.
// The master drives the operands; the slave (the comparator) returns the flags.
interface cmp_sweep_checker_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_equal;
    logic             cmp_greater;
    logic             cmp_lesser;

    modport master (
        output cmp_a, cmp_b,
        input  cmp_equal, cmp_greater, cmp_lesser
    );

    modport slave (
        input  cmp_a, cmp_b,
        output cmp_equal, cmp_greater, cmp_lesser
    );

endinterface

// File: rtl/cmp_expect.sv
// Combinational golden model that maps an operand pair to the flags a correct
// comparator must produce.
module cmp_expect
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output flags_t           exp_o
);

    assign exp_o = expect_flags(MAX_WIDTH'(a_i), MAX_WIDTH'(b_i));

endmodule

// File: rtl/cmp_sweep_checker.sv
// Built-in self-test sequencer: sweeps every operand pair through the comparator,
// scores its flags against the golden model and records the first failing pair.
module cmp_sweep_checker
    import cmp_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    cmp_sweep_checker_if.master   cmp,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*WIDTH:0]      err_count,
    output logic                  fail_valid,
    output logic [WIDTH-1:0]      fail_a,
    output logic [WIDTH-1:0]      fail_b
);

    localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   settle_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   fail_a_q, fail_b_q;
    logic [2*WIDTH:0]   err_q;
    logic               busy_q, done_q, pass_q, fail_valid_q;

    flags_t             exp_flags;
    flags_t             got_flags;
    logic               mismatch;
    logic               last_pair;
    logic [2*WIDTH-1:0] pair_d;
    logic [2*WIDTH:0]   err_d;

    cmp_expect #(.WIDTH(WIDTH)) u_expect (
        .a_i   (a_q),
        .b_i   (b_q),
        .exp_o (exp_flags)
    );

    // Any deviation counts, so non-one-hot flag patterns are always errors.
    assign got_flags = {cmp.cmp_equal, cmp.cmp_greater, cmp.cmp_lesser};
    assign mismatch  = (got_flags != exp_flags);
    assign last_pair = &{a_q, b_q};
    assign pair_d    = {a_q, b_q} + (2*WIDTH)'(1);
    assign err_d     = err_q + (2*WIDTH+1)'(mismatch);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q          <= '0;
                        b_q          <= '0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        settle_q     <= SETTLE_LOAD;
                        state_q      <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - CNT_W'(1);
                    end
                end
                CHECK: begin
                    err_q <= err_d;
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_a_q     <= a_q;
                        fail_b_q     <= b_q;
                    end
                    if (last_pair) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= FINISH;
                    end else begin
                        {a_q, b_q} <= pair_d;
                        settle_q   <= SETTLE_LOAD;
                        state_q    <= APPLY;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmp.cmp_a  = a_q;
    assign cmp.cmp_b  = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: a behavioural comparator with selectable faults,
// a per-cycle sweep model, and directed scenarios with literal expectations.
module tb_cmp_sweep_checker;

    localparam int W     = 4;
    localparam int S     = 1;
    localparam int NP    = 1 << (2*W);
    localparam int SWEEP = NP*(S+1) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           start3 = 1'b0;

    logic           busy, done, pass, fail_valid;
    logic [2*W:0]   err_count;
    logic [W-1:0]   fail_a, fail_b;
    logic           busy3, done3, pass3, fail_valid3;
    logic [2*W:0]   err_count3;
    logic [W-1:0]   fail_a3, fail_b3;

    int fault_mode = 0;   // 0 good, 1 greater stuck 0, 2 greater/lesser swapped, 3 equal stuck 1
    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int t0         = 0;
    bit track      = 1'b0;
    int done_cnt   = 0;

    bit faulty [NP];
    int prefix [NP+1];
    int first_idx;
    int ct, ck, cp;

    cmp_sweep_checker_if #(.WIDTH(W)) bus  ();
    cmp_sweep_checker_if #(.WIDTH(W)) bus3 ();

    cmp_sweep_checker #(.WIDTH(W), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmp(bus),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
    );

    cmp_sweep_checker #(.WIDTH(W), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cmp(bus3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .fail_valid(fail_valid3), .fail_a(fail_a3), .fail_b(fail_b3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    // Comparator under test, with injectable faults.
    assign bus.cmp_equal   = (fault_mode == 3) ? 1'b1 : (bus.cmp_a == bus.cmp_b);
    assign bus.cmp_greater = (fault_mode == 1) ? 1'b0 :
                             (fault_mode == 2) ? (bus.cmp_a < bus.cmp_b) : (bus.cmp_a > bus.cmp_b);
    assign bus.cmp_lesser  = (fault_mode == 2) ? (bus.cmp_a > bus.cmp_b) : (bus.cmp_a < bus.cmp_b);

    assign bus3.cmp_equal   = (bus3.cmp_a == bus3.cmp_b);
    assign bus3.cmp_greater = (bus3.cmp_a > bus3.cmp_b);
    assign bus3.cmp_lesser  = (bus3.cmp_a < bus3.cmp_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] observed(input int mode, input int a, input int b);
        logic eq, gt, lt;
        eq = (mode == 3) ? 1'b1 : (a == b);
        gt = (mode == 1) ? 1'b0 : (mode == 2) ? (a < b) : (a > b);
        lt = (mode == 2) ? (a > b) : (a < b);
        return {eq, gt, lt};
    endfunction

    // Which pairs a faulty comparator gets wrong, and running error totals in sweep order.
    task automatic build_model(input int mode);
        int a, b;
        logic [2:0] want;
        prefix[0] = 0;
        first_idx = NP;
        for (int p = 0; p < NP; p++) begin
            a = p >> W;
            b = p % (1 << W);
            want = {a == b, a > b, a < b};
            faulty[p] = (observed(mode, a, b) != want);
            prefix[p+1] = prefix[p] + (faulty[p] ? 1 : 0);
            if (faulty[p] && first_idx == NP) first_idx = p;
        end
    endtask

    // Cycle t after the start edge: pair index (t-1)/(S+1), k pairs already scored.
    always @(negedge clk) begin
        if (track) begin
            ct = cyc - t0 + 1;
            cp = (ct <= NP*(S+1)) ? (ct - 1) / (S+1) : NP - 1;
            ck = (ct - 1) / (S+1);
            if (ck > NP) ck = NP;
            check("cyc_a",     32'(bus.cmp_a), 32'(cp >> W));
            check("cyc_b",     32'(bus.cmp_b), 32'(cp % (1 << W)));
            check("cyc_busy",  32'(busy),      32'(ct <= NP*(S+1)));
            check("cyc_done",  32'(done),      32'(ct == SWEEP));
            check("cyc_err",   32'(err_count), 32'(prefix[ck]));
            check("cyc_fv",    32'(fail_valid), 32'(ck > first_idx));
            check("cyc_pass",  32'(pass),      32'(ct == SWEEP && prefix[NP] == 0));
            if (ck > first_idx) begin
                check("cyc_fa", 32'(fail_a), 32'(first_idx >> W));
                check("cyc_fb", 32'(fail_b), 32'(first_idx % (1 << W)));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_a"},    32'(bus.cmp_a), 0);
        check({tag, "_b"},    32'(bus.cmp_b), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_err"},  32'(err_count), 0);
        check({tag, "_fv"},   32'(fail_valid), 0);
        check({tag, "_fa"},   32'(fail_a), 0);
        check({tag, "_fb"},   32'(fail_b), 0);
    endtask

    task automatic run_sweep(input int mode, input int repulse_at, input int abort_at,
                             input int exp_err, input int exp_fa, input int exp_fb, input bit exp_fv);
        int d0;
        fault_mode = mode;
        build_model(mode);
        check("model_total", 32'(prefix[NP]), 32'(exp_err));
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        track = 1'b1;
        start = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            #1 track = 1'b0;
            @(negedge clk) rst_n = 1'b0;
            #1 check_reset_values("abort");
            repeat (5) @(negedge clk);
            #1;
            check("abort_no_done", 32'(done_cnt - d0), 0);
            check_reset_values("abort_hold");
            rst_n = 1'b1;
            return;
        end
        if (repulse_at > 0) begin
            repeat (repulse_at - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (SWEEP - repulse_at) @(negedge clk);
        end else begin
            repeat (SWEEP) @(negedge clk);
        end
        #1 track = 1'b0;
        check("end_done", 32'(done), 1);
        check("end_err",  32'(err_count), 32'(exp_err));
        check("end_fv",   32'(fail_valid), 32'(exp_fv));
        check("end_pass", 32'(pass), 32'(exp_err == 0));
        if (exp_fv) begin
            check("end_fa", 32'(fail_a), 32'(exp_fa));
            check("end_fb", 32'(fail_b), 32'(exp_fb));
        end
        repeat (4) @(negedge clk);
        #1;
        check("one_done",  32'(done_cnt - d0), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_a",    32'(bus.cmp_a), 15);
        check("idle_b",    32'(bus.cmp_b), 15);
        check("hold_err",  32'(err_count), 32'(exp_err));
        check("hold_pass", 32'(pass), 32'(exp_err == 0));
    endtask

    initial begin
        int n;
        bit found;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        check("reset_busy3", 32'(busy3), 0);
        rst_n = 1'b1;

        run_sweep(0, 0,   0,   0, 0, 0, 1'b0);
        run_sweep(1, 0,   0, 120, 1, 0, 1'b1);
        run_sweep(2, 0,   0, 240, 0, 1, 1'b1);
        run_sweep(3, 0,   0, 240, 0, 1, 1'b1);
        run_sweep(0, 50,  0,   0, 0, 0, 1'b0);
        run_sweep(1, 0, 100, 120, 1, 0, 1'b1);
        run_sweep(0, 0,   0,   0, 0, 0, 1'b0);

        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            n++;
            if (done3) begin
                found = 1'b1;
                break;
            end
        end
        check("s3_found", 32'(found), 1);
        check("s3_len",   32'(n), 1025);
        check("s3_pass",  32'(pass3), 1);
        check("s3_err",   32'(err_count3), 0);
        check("s3_fv",    32'(fail_valid3), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
